// File: rtl/cache_cpu_port.sv
// CPU-side load/store sequencer for the cache precycle/cycle address protocol.
// Optional miss-timeout fault: define CACHEPORT_TIMEOUT_EN.
module cache_cpu_port #(
  parameter int unsigned REFRACT_CYC = 1,
  parameter int unsigned TLB_HOLD    = 4,
  parameter int unsigned TIMEOUT_W   = 8,
  parameter int unsigned TIMEOUT_MAX = 200
) (
  input  logic        CPU_CLK,
  input  logic        RST,
  input  logic        cpu_req_valid,
  input  logic [31:0] cpu_req_addr,
  input  logic        cpu_req_we,
  input  logic        cpu_req_tlb,
  input  logic [31:0] cpu_req_wdata,
  output logic        cpu_req_ready,
  output logic        cpu_rsp_valid,
  output logic [31:0] cpu_rsp_data,
  output logic        cpu_fault,
  output logic [31:0] aexm_cache_precycle_addr,
  output logic [31:0] aexm_cache_cycle_addr,
  output logic        aexm_cache_cycle_we,
  output logic [31:0] aexm_cache_datao,
  output logic        WE_TLB,
  input  logic        aexm_cache_cachebusy_n,
  input  logic [31:0] aexm_cache_datai
);

  localparam int unsigned HOLD_W = (TLB_HOLD > 32'd1) ? $clog2(TLB_HOLD) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOOK = 3'd1,
    WR   = 3'd2,
    TLBW = 3'd3,
    REFR = 3'd4
  } state_t;

  state_t            state_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [1:0]        refr_cnt_r;
  logic              accept_s;
`ifdef CACHEPORT_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt_r;
`endif

  if (REFRACT_CYC < 32'd1 || REFRACT_CYC > 32'd3 || TLB_HOLD < 32'd1 ||
      TIMEOUT_W < 32'd1 || TIMEOUT_MAX < 32'd1) begin : g_param_check
    $error("cache_cpu_port: parameter out of range");
  end

  // RAM read address: the new request on accept, otherwise re-read the access under evaluation.
  always_comb begin
    accept_s = cpu_req_valid & cpu_req_ready;
    if (accept_s) begin
      aexm_cache_precycle_addr = cpu_req_addr;
    end else begin
      aexm_cache_precycle_addr = aexm_cache_cycle_addr;
    end
  end

  // Request sequencer with registered CPU and cache-side outputs.
  always_ff @(posedge CPU_CLK) begin
    if (!RST) begin
      state_r               <= IDLE;
      hold_cnt_r            <= '0;
      refr_cnt_r            <= 2'd0;
      cpu_req_ready         <= 1'b0;
      cpu_rsp_valid         <= 1'b0;
      cpu_rsp_data          <= 32'd0;
      cpu_fault             <= 1'b0;
      aexm_cache_cycle_addr <= 32'd0;
      aexm_cache_cycle_we   <= 1'b0;
      aexm_cache_datao      <= 32'd0;
      WE_TLB                <= 1'b0;
`ifdef CACHEPORT_TIMEOUT_EN
      tmo_cnt_r             <= '0;
`endif
    end else begin
      aexm_cache_cycle_addr <= aexm_cache_precycle_addr;
      cpu_rsp_valid         <= 1'b0;
      cpu_rsp_data          <= 32'd0;
      cpu_fault             <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cpu_req_ready <= 1'b0;
`ifdef CACHEPORT_TIMEOUT_EN
            tmo_cnt_r     <= '0;
`endif
            if (!cpu_req_we) begin
              state_r <= LOOK;
            end else if (cpu_req_tlb) begin
              state_r          <= TLBW;
              WE_TLB           <= 1'b1;
              aexm_cache_datao <= cpu_req_wdata;
              hold_cnt_r       <= '0;
            end else begin
              state_r             <= WR;
              aexm_cache_cycle_we <= 1'b1;
              aexm_cache_datao    <= cpu_req_wdata;
            end
          end else begin
            // Also covers the response cycle of a read, which must not show ready.
            cpu_req_ready <= 1'b1;
          end
        end
        LOOK: begin
          if (aexm_cache_cachebusy_n) begin
            cpu_rsp_valid <= 1'b1;
            cpu_rsp_data  <= aexm_cache_datai;
            state_r       <= IDLE;
          end else begin
`ifdef CACHEPORT_TIMEOUT_EN
            if (tmo_cnt_r == TIMEOUT_W'(TIMEOUT_MAX - 32'd1)) begin
              cpu_rsp_valid <= 1'b1;
              cpu_fault     <= 1'b1;
              state_r       <= IDLE;
            end else begin
              tmo_cnt_r <= tmo_cnt_r + TIMEOUT_W'(1);
            end
`endif
          end
        end
        WR: begin
          if (aexm_cache_cachebusy_n) begin
            aexm_cache_cycle_we <= 1'b0;
            cpu_rsp_valid       <= 1'b1;
            refr_cnt_r          <= 2'd0;
            state_r             <= REFR;
          end else begin
`ifdef CACHEPORT_TIMEOUT_EN
            if (tmo_cnt_r == TIMEOUT_W'(TIMEOUT_MAX - 32'd1)) begin
              aexm_cache_cycle_we <= 1'b0;
              cpu_rsp_valid       <= 1'b1;
              cpu_fault           <= 1'b1;
              refr_cnt_r          <= 2'd0;
              state_r             <= REFR;
            end else begin
              tmo_cnt_r <= tmo_cnt_r + TIMEOUT_W'(1);
            end
`endif
          end
        end
        TLBW: begin
          if (hold_cnt_r == HOLD_W'(TLB_HOLD - 32'd1)) begin
            WE_TLB        <= 1'b0;
            cpu_rsp_valid <= 1'b1;
            refr_cnt_r    <= 2'd0;
            state_r       <= REFR;
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end
        end
        REFR: begin
          if (refr_cnt_r == 2'(REFRACT_CYC - 32'd1)) begin
            cpu_req_ready <= 1'b1;
            state_r       <= IDLE;
          end else begin
            refr_cnt_r <= refr_cnt_r + 2'd1;
          end
        end
        default: begin
          state_r             <= IDLE;
          cpu_req_ready       <= 1'b0;
          aexm_cache_cycle_we <= 1'b0;
          WE_TLB              <= 1'b0;
        end
      endcase
    end
  end

endmodule
